updown_counter_gen: RTL and testbench

Parametrised up/down counter. It succeeds the fixed 5-bit en/sel counter. Adds configurable width and count range, programmable step, synchronous parallel load, and a selectable wrap/saturate mode. It also provides boundary flags and a terminal-count pulse. Used as a generic timer/index source in datapath and control blocks.

---
 rtl/updown_counter_gen.sv | 130 +++++++++++++
 tb/tb_updown_counter_gen.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/updown_counter_gen.sv
// updown_counter_gen: parametrised up/down counter with programmable step,
// synchronous parallel load, wrap/saturate range handling, boundary flags
// and a terminal-count pulse.
//
// Ports:
//   clk       in   rising-edge clock for all state
//   reset     in   synchronous active-low reset (0 = reset)
//   en        in   count enable (0 = hold)
//   sel       in   direction: 0 = up, 1 = down
//   load      in   synchronous parallel load request
//   load_val  in   [WIDTH]   value loaded when load = 1
//   sat_mode  in   0 = wrap at range ends, 1 = saturate at range ends
//   step      in   [STEP_W]  count magnitude (0 behaves as hold)
//   out       out  [WIDTH]   registered count, always within [MIN_VAL, MAX_VAL]
//   at_max    out  combinational, out == MAX_VAL
//   at_min    out  combinational, out == MIN_VAL
//   tc        out  registered terminal-count pulse (range end crossed/hit)
//   load_err  out  registered, last accepted load_val was out of range
//
// There is no handshake: every input is sampled on each rising edge with
// priority reset > load > en, and the result appears on the registered
// outputs one cycle later.
module updown_counter_gen #(
   parameter int          WIDTH   = 5,
   parameter int unsigned MIN_VAL = 0,
   parameter int unsigned MAX_VAL = 32'hFFFF_FFFF >> (32 - WIDTH),
   parameter int          STEP_W  = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic              sel,
   input  logic              load,
   input  logic [WIDTH-1:0]  load_val,
   input  logic              sat_mode,
   input  logic [STEP_W-1:0] step,
   output logic [WIDTH-1:0]  out,
   output logic              at_max,
   output logic              at_min,
   output logic              tc,
   output logic              load_err
);

   // Two guard bits: one for the carry of out+step, one so out-step can go
   // negative and still be compared as a signed value.
   localparam int XW = WIDTH + 2;

   localparam logic [XW-1:0]    MIN_X   = XW'(MIN_VAL);
   localparam logic [XW-1:0]    MAX_X   = XW'(MAX_VAL);
   localparam logic [XW-1:0]    RANGE_X = MAX_X - MIN_X + XW'(1);
   localparam logic [WIDTH-1:0] MIN_W   = WIDTH'(MIN_VAL);
   localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_VAL);

   logic [WIDTH-1:0] out_q;
   logic             tc_q;
   logic             load_err_q;

   logic [XW-1:0]    cur_x;
   logic [XW-1:0]    step_x;
   logic [XW-1:0]    eff_step;
   logic [XW-1:0]    load_x;
   logic [XW-1:0]    up_sum;
   logic [XW-1:0]    dn_diff;
   logic [WIDTH-1:0] nxt_out;
   logic             nxt_tc;
   logic             nxt_err;

   always_comb begin
      cur_x    = XW'(out_q);
      step_x   = XW'(step);
      // A step larger than the whole range would wrap more than once;
      // clamping to RANGE keeps a single wrap correct.
      eff_step = (step_x > RANGE_X) ? RANGE_X : step_x;
      load_x   = XW'(load_val);
      up_sum   = cur_x + eff_step;
      dn_diff  = cur_x - eff_step;

      nxt_out  = out_q;
      nxt_tc   = 1'b0;
      nxt_err  = 1'b0;

      if (load) begin
         if (load_x > MAX_X) begin
            nxt_out = MAX_W;
            nxt_err = 1'b1;
         end else if (load_x < MIN_X) begin
            nxt_out = MIN_W;
            nxt_err = 1'b1;
         end else begin
            nxt_out = load_val;
         end
      end else if (en && (step != '0)) begin
         if (!sel) begin
            if (up_sum <= MAX_X) begin
               nxt_out = WIDTH'(up_sum);
            end else begin
               nxt_tc  = 1'b1;
               nxt_out = sat_mode ? MAX_W : WIDTH'(up_sum - RANGE_X);
            end
         end else begin
            // Signed compare so an underflow below zero is seen as below MIN.
            if ($signed(dn_diff) >= $signed(MIN_X)) begin
               nxt_out = WIDTH'(dn_diff);
            end else begin
               nxt_tc  = 1'b1;
               nxt_out = sat_mode ? MIN_W : WIDTH'(dn_diff + RANGE_X);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         out_q      <= MIN_W;
         tc_q       <= 1'b0;
         load_err_q <= 1'b0;
      end else begin
         out_q      <= nxt_out;
         tc_q       <= nxt_tc;
         load_err_q <= nxt_err;
      end
   end

   assign out      = out_q;
   assign tc       = tc_q;
   assign load_err = load_err_q;
   assign at_max   = (out_q == MAX_W);
   assign at_min   = (out_q == MIN_W);

endmodule

// File: tb/tb_updown_counter_gen.sv
module tb_updown_counter_gen;

   localparam int LO  = 2;
   localparam int HI  = 23;
   localparam int RNG = HI - LO + 1;

   // ---------------- clock / reset block ----------------
   logic clk = 1'b0;
   always #4 clk = ~clk;

   logic       reset, en, sel, load, sat_mode;
   logic [4:0] load_val;
   logic [2:0] step;
   logic [4:0] out;
   logic       at_max, at_min, tc, load_err;

   logic       lg_reset, lg_en, lg_sel, lg_load, lg_sat_mode;
   logic [4:0] lg_load_val;
   logic [2:0] lg_step;
   logic [4:0] lg_out;
   logic       lg_at_max, lg_at_min, lg_tc, lg_load_err;

   int checks = 0;
   int errors = 0;

   updown_counter_gen #(.WIDTH(5), .MIN_VAL(LO), .MAX_VAL(HI), .STEP_W(3)) u_dut (
      .clk(clk), .reset(reset), .en(en), .sel(sel), .load(load),
      .load_val(load_val), .sat_mode(sat_mode), .step(step),
      .out(out), .at_max(at_max), .at_min(at_min), .tc(tc), .load_err(load_err)
   );

   updown_counter_gen #(.WIDTH(5), .MIN_VAL(0), .MAX_VAL(31), .STEP_W(3)) u_legacy (
      .clk(clk), .reset(lg_reset), .en(lg_en), .sel(lg_sel), .load(lg_load),
      .load_val(lg_load_val), .sat_mode(lg_sat_mode), .step(lg_step),
      .out(lg_out), .at_max(lg_at_max), .at_min(lg_at_min), .tc(lg_tc),
      .load_err(lg_load_err)
   );

   // ---------------- reference model (range arithmetic on ints) ----------------
   int m_out = LO;
   bit m_tc  = 1'b0;
   bit m_err = 1'b0;

   function automatic void model_step(input bit r, input bit e, input bit sl,
                                      input bit ld, input int lv, input bit sm,
                                      input int st);
      int s;
      int n;
      m_tc  = 1'b0;
      m_err = 1'b0;
      if (!r) begin
         m_out = LO;
      end else if (ld) begin
         if (lv > HI) begin m_out = HI; m_err = 1'b1; end
         else if (lv < LO) begin m_out = LO; m_err = 1'b1; end
         else m_out = lv;
      end else if (e && st != 0) begin
         s = (st < RNG) ? st : RNG;
         n = sl ? m_out - s : m_out + s;
         if (n > HI) begin m_tc = 1'b1; n = sm ? HI : n - RNG; end
         if (n < LO) begin m_tc = 1'b1; n = sm ? LO : n + RNG; end
         m_out = n;
      end
   endfunction

   // ---------------- driver tasks ----------------
   task automatic apply(input bit r, input bit e, input bit sl, input bit ld,
                        input int lv, input bit sm, input int st);
      reset    = r;
      en       = e;
      sel      = sl;
      load     = ld;
      load_val = 5'(lv);
      sat_mode = sm;
      step     = 3'(st);
      @(posedge clk);
      model_step(r, e, sl, ld, lv, sm, st);
      #2;
   endtask

   task automatic lapply(input bit r, input bit e, input bit sl, input bit ld,
                         input int lv);
      lg_reset    = r;
      lg_en       = e;
      lg_sel      = sl;
      lg_load     = ld;
      lg_load_val = 5'(lv);
      lg_sat_mode = 1'b0;
      lg_step     = 3'd1;
      @(posedge clk);
      #2;
   endtask

   typedef struct {
      bit r; bit e; bit sl; bit ld; int lv; bit sm; int st;
      int eo; bit et; bit ee;
   } row_t;

   // ---------------- scenarios ----------------
   task automatic test_reset();
      row_t t[5] = '{'{0,0,0,0,0,0,0, 2,0,0}, '{0,0,0,0,0,0,0, 2,0,0},
                     '{1,0,0,0,0,0,0, 2,0,0}, '{1,0,0,0,0,0,0, 2,0,0},
                     '{1,0,0,0,0,0,0, 2,0,0}};
      for (int i = 0; i < 5; i++) begin
         apply(t[i].r, t[i].e, t[i].sl, t[i].ld, t[i].lv, t[i].sm, t[i].st);
         checks++; if (out !== 5'(t[i].eo)) begin errors++; $display("FAIL reset[%0d] out: got %0d want %0d", i, out, t[i].eo); end
         checks++; if (tc !== t[i].et) begin errors++; $display("FAIL reset[%0d] tc: got %b want %b", i, tc, t[i].et); end
         checks++; if (load_err !== t[i].ee) begin errors++; $display("FAIL reset[%0d] load_err: got %b want %b", i, load_err, t[i].ee); end
         checks++; if (at_min !== 1'b1 || at_max !== 1'b0) begin errors++; $display("FAIL reset[%0d] flags: got min=%b max=%b want min=1 max=0", i, at_min, at_max); end
      end
   endtask

   task automatic test_wrap_up();
      row_t t[3] = '{'{1,0,0,1,21,0,0, 21,0,0}, '{1,1,0,0,0,0,3, 2,1,0},
                     '{1,1,0,0,0,0,3, 5,0,0}};
      for (int i = 0; i < 3; i++) begin
         apply(t[i].r, t[i].e, t[i].sl, t[i].ld, t[i].lv, t[i].sm, t[i].st);
         checks++; if (out !== 5'(t[i].eo)) begin errors++; $display("FAIL wrap_up[%0d] out: got %0d want %0d", i, out, t[i].eo); end
         checks++; if (tc !== t[i].et) begin errors++; $display("FAIL wrap_up[%0d] tc: got %b want %b", i, tc, t[i].et); end
         checks++; if (at_min !== (t[i].eo == LO)) begin errors++; $display("FAIL wrap_up[%0d] at_min: got %b want %b", i, at_min, (t[i].eo == LO)); end
      end
   endtask

   task automatic test_saturate();
      row_t t[6] = '{'{1,0,0,1,4,1,0, 4,0,0}, '{1,1,1,0,0,1,3, 2,1,0},
                     '{1,1,1,0,0,1,3, 2,1,0}, '{1,0,0,1,22,1,0, 22,0,0},
                     '{1,1,0,0,0,1,3, 23,1,0}, '{1,1,0,0,0,1,3, 23,1,0}};
      for (int i = 0; i < 6; i++) begin
         apply(t[i].r, t[i].e, t[i].sl, t[i].ld, t[i].lv, t[i].sm, t[i].st);
         checks++; if (out !== 5'(t[i].eo)) begin errors++; $display("FAIL saturate[%0d] out: got %0d want %0d", i, out, t[i].eo); end
         checks++; if (tc !== t[i].et) begin errors++; $display("FAIL saturate[%0d] tc: got %b want %b", i, tc, t[i].et); end
         checks++; if (at_min !== (t[i].eo == LO)) begin errors++; $display("FAIL saturate[%0d] at_min: got %b want %b", i, at_min, (t[i].eo == LO)); end
         checks++; if (at_max !== (t[i].eo == HI)) begin errors++; $display("FAIL saturate[%0d] at_max: got %b want %b", i, at_max, (t[i].eo == HI)); end
      end
   endtask

   task automatic test_load_range();
      row_t t[6] = '{'{1,0,0,1,30,0,0, 23,0,1}, '{1,0,0,0,0,0,0, 23,0,0},
                     '{1,0,0,1,0,0,0, 2,0,1},   '{1,1,0,1,1,0,5, 2,0,1},
                     '{1,0,0,1,23,0,0, 23,0,0}, '{1,0,0,1,2,0,0, 2,0,0}};
      for (int i = 0; i < 6; i++) begin
         apply(t[i].r, t[i].e, t[i].sl, t[i].ld, t[i].lv, t[i].sm, t[i].st);
         checks++; if (out !== 5'(t[i].eo)) begin errors++; $display("FAIL load_range[%0d] out: got %0d want %0d", i, out, t[i].eo); end
         checks++; if (load_err !== t[i].ee) begin errors++; $display("FAIL load_range[%0d] load_err: got %b want %b", i, load_err, t[i].ee); end
         checks++; if (tc !== t[i].et) begin errors++; $display("FAIL load_range[%0d] tc: got %b want %b", i, tc, t[i].et); end
         checks++; if (at_max !== (t[i].eo == HI)) begin errors++; $display("FAIL load_range[%0d] at_max: got %b want %b", i, at_max, (t[i].eo == HI)); end
      end
   endtask

   task automatic test_priority();
      row_t t[4] = '{'{1,1,0,1,10,0,3, 10,0,0}, '{0,1,0,1,20,0,3, 2,0,0},
                     '{1,0,0,1,30,0,0, 23,0,1}, '{0,1,0,0,0,0,3, 2,0,0}};
      for (int i = 0; i < 4; i++) begin
         apply(t[i].r, t[i].e, t[i].sl, t[i].ld, t[i].lv, t[i].sm, t[i].st);
         checks++; if (out !== 5'(t[i].eo)) begin errors++; $display("FAIL priority[%0d] out: got %0d want %0d", i, out, t[i].eo); end
         checks++; if (tc !== t[i].et) begin errors++; $display("FAIL priority[%0d] tc: got %b want %b", i, tc, t[i].et); end
         checks++; if (load_err !== t[i].ee) begin errors++; $display("FAIL priority[%0d] load_err: got %b want %b", i, load_err, t[i].ee); end
      end
   endtask

   task automatic test_step_edges();
      // step 0 holds; 17+7 wraps exactly onto MIN; 2-1 wraps onto MAX
      row_t t[6] = '{'{1,0,0,1,10,0,0, 10,0,0}, '{1,1,0,0,0,0,0, 10,0,0},
                     '{1,1,1,0,0,1,0, 10,0,0},  '{1,1,0,0,0,0,7, 17,0,0},
                     '{1,1,0,0,0,0,7, 2,1,0},   '{1,1,1,0,0,0,1, 23,1,0}};
      for (int i = 0; i < 6; i++) begin
         apply(t[i].r, t[i].e, t[i].sl, t[i].ld, t[i].lv, t[i].sm, t[i].st);
         checks++; if (out !== 5'(t[i].eo)) begin errors++; $display("FAIL step_edges[%0d] out: got %0d want %0d", i, out, t[i].eo); end
         checks++; if (tc !== t[i].et) begin errors++; $display("FAIL step_edges[%0d] tc: got %b want %b", i, tc, t[i].et); end
      end
   endtask

   task automatic test_random();
      bit r, e, sl, ld, sm;
      int lv, st;
      for (int i = 0; i < 400; i++) begin
         r  = ($urandom_range(0, 39) != 0);
         ld = ($urandom_range(0, 7) == 0);
         e  = ($urandom_range(0, 3) != 0);
         sl = 1'($urandom_range(0, 1));
         sm = 1'($urandom_range(0, 1));
         lv = $urandom_range(0, 31);
         st = $urandom_range(0, 7);
         apply(r, e, sl, ld, lv, sm, st);
         checks++; if (out !== 5'(m_out)) begin errors++; $display("FAIL random[%0d] out: got %0d want %0d", i, out, m_out); end
         checks++; if (tc !== m_tc) begin errors++; $display("FAIL random[%0d] tc: got %b want %b", i, tc, m_tc); end
         checks++; if (load_err !== m_err) begin errors++; $display("FAIL random[%0d] load_err: got %b want %b", i, load_err, m_err); end
         checks++; if (at_max !== (m_out == HI) || at_min !== (m_out == LO)) begin errors++; $display("FAIL random[%0d] flags: got max=%b min=%b want max=%b min=%b", i, at_max, at_min, (m_out == HI), (m_out == LO)); end
      end
   endtask

   task automatic test_legacy();
      row_t t[9] = '{'{0,0,0,0,0,0,1, 0,0,0},  '{1,0,0,1,30,0,1, 30,0,0},
                     '{1,1,0,0,0,0,1, 31,0,0}, '{1,1,0,0,0,0,1, 0,1,0},
                     '{1,1,0,0,0,0,1, 1,0,0},  '{1,0,0,1,0,0,1, 0,0,0},
                     '{1,1,1,0,0,0,1, 31,1,0}, '{1,0,1,0,0,0,1, 31,0,0},
                     '{1,0,0,0,0,0,1, 31,0,0}};
      for (int i = 0; i < 9; i++) begin
         lapply(t[i].r, t[i].e, t[i].sl, t[i].ld, t[i].lv);
         checks++; if (lg_out !== 5'(t[i].eo)) begin errors++; $display("FAIL legacy[%0d] out: got %0d want %0d", i, lg_out, t[i].eo); end
         checks++; if (lg_tc !== t[i].et) begin errors++; $display("FAIL legacy[%0d] tc: got %b want %b", i, lg_tc, t[i].et); end
         checks++; if (lg_at_max !== (t[i].eo == 31)) begin errors++; $display("FAIL legacy[%0d] at_max: got %b want %b", i, lg_at_max, (t[i].eo == 31)); end
      end
   endtask

   // ---------------- sequence and final report ----------------
   initial begin
      lg_reset = 1'b0; lg_en = 1'b0; lg_sel = 1'b0; lg_load = 1'b0;
      lg_load_val = '0; lg_sat_mode = 1'b0; lg_step = 3'd1;
      test_reset();
      test_wrap_up();
      test_saturate();
      test_load_range();
      test_priority();
      test_step_edges();
      test_random();
      reset = 1'b1; en = 1'b0; load = 1'b0;
      test_legacy();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
